// File: rtl/spi_word_fifo_pkg.sv
// Shared types and constants for the SPI prefetch word FIFO.
package spi_word_fifo_pkg;

    // Control state of the prefetch engine
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } fifo_state_e;

    // Request guard: a word may only be captured two cycles after its request pulse
    localparam int unsigned GUARD_W = 2;
    localparam logic [GUARD_W-1:0] GUARD_EXPIRED = 2'd2;

    // True once the guard window after a request has elapsed
    function automatic logic guard_done(input logic [GUARD_W-1:0] guard);
        return guard >= GUARD_EXPIRED;
    endfunction

endpackage

// File: rtl/word_fifo_mem.sv
// Word storage for the prefetch FIFO: synchronous write, asynchronous read.
// Kept separate so the register array can be swapped for a block-RAM variant.
module word_fifo_mem #(
    parameter int unsigned W      = 16,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [W-1:0] mem_q [DEPTH];

    // Register array, cleared on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_word_fifo.sv
// Prefetch FIFO between the SPI flash controller and the RLE video decoder.
// Issues start/continue/stop commands, keeps up to 2^DEPTH_LOG2 words queued
// and offers a valid/pop interface to the consumer.
module spi_word_fifo
    import spi_word_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_BYTES = 2,
    parameter int unsigned DEPTH_LOG2       = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          read_next,
    input  logic                          stop_read,
    output logic                          data_ready,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          underflow,
    output logic                          spi_start_read,
    output logic                          spi_continue_read,
    output logic                          spi_stop_read,
    input  logic [8*DATA_WIDTH_BYTES-1:0] spi_data_in,
    input  logic                          spi_busy
);

    localparam int unsigned W     = 8 * DATA_WIDTH_BYTES;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    fifo_state_e        state_q, state_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               pending_q, pending_d;
    logic [GUARD_W-1:0] guard_q, guard_d;

    logic               underflow_d;
    logic               data_ready_d;
    logic               start_d, cont_d, stop_d;
    logic [W-1:0]       data_out_d;

    logic               push_c;
    logic               pop_c;
    logic [W-1:0]       rd_data;

    // Next-state logic: commands, capture, pop, refill and flush
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        guard_d     = guard_q;
        underflow_d = underflow;
        start_d     = 1'b0;
        cont_d      = 1'b0;
        stop_d      = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;

        if (!guard_done(guard_q)) begin
            guard_d = guard_q + GUARD_W'(1);
        end

        if (stop_read) begin
            // Flush everything; any word still in flight is ignored
            stop_d    = 1'b1;
            state_d   = ST_IDLE;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            pending_d = 1'b0;
            guard_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (read_next) begin
                        start_d   = 1'b1;
                        pending_d = 1'b1;
                        guard_d   = '0;
                        state_d   = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    push_c = pending_q && guard_done(guard_q) && !spi_busy;
                    pop_c  = read_next && (count_q != '0);
                    if (read_next && (count_q == '0)) begin
                        underflow_d = 1'b1;
                    end
                    if (push_c) begin
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                        pending_d = 1'b0;
                    end
                    if (pop_c) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                    count_d = count_q + CW'(push_c) - CW'(pop_c);
                    // One request outstanding at most; never ask when full
                    if (!pending_q && !spi_start_read && !spi_continue_read &&
                        (count_d < CW'(DEPTH))) begin
                        cont_d    = 1'b1;
                        pending_d = 1'b1;
                        guard_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        data_ready_d = (state_d == ST_STREAM) && (count_d != '0);
    end

    // Next head word, forwarding a capture that lands on an empty slot at the head
    always_comb begin
        data_out_d = rd_data;
        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            data_out_d = spi_data_in;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= ST_IDLE;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            pending_q         <= 1'b0;
            guard_q           <= '0;
            underflow         <= 1'b0;
            data_ready        <= 1'b0;
            data_out          <= '0;
            spi_start_read    <= 1'b0;
            spi_continue_read <= 1'b0;
            spi_stop_read     <= 1'b0;
        end else begin
            state_q           <= state_d;
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            count_q           <= count_d;
            pending_q         <= pending_d;
            guard_q           <= guard_d;
            underflow         <= underflow_d;
            data_ready        <= data_ready_d;
            data_out          <= data_out_d;
            spi_start_read    <= start_d;
            spi_continue_read <= cont_d;
            spi_stop_read     <= stop_d;
        end
    end

    // Word storage, read at the next head position
    word_fifo_mem #(
        .W      (W),
        .ADDR_W (PW)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (spi_data_in),
        .raddr (rd_ptr_d),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_spi_word_fifo.sv
// Self-checking bench for spi_word_fifo: SPI controller model, queue-based
// reference model, per-cycle compare and directed scenarios.
module tb_spi_word_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         read_next;
    logic         stop_read;
    logic         data_ready;
    logic [W-1:0] data_out;
    logic         underflow;
    logic         spi_start_read;
    logic         spi_continue_read;
    logic         spi_stop_read;
    logic [W-1:0] spi_data_in;
    logic         spi_busy;

    int tests  = 0;
    int errors = 0;

    spi_word_fifo #(
        .DATA_WIDTH_BYTES (2),
        .DEPTH_LOG2       (2)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .read_next         (read_next),
        .stop_read         (stop_read),
        .data_ready        (data_ready),
        .data_out          (data_out),
        .underflow         (underflow),
        .spi_start_read    (spi_start_read),
        .spi_continue_read (spi_continue_read),
        .spi_stop_read     (spi_stop_read),
        .spi_data_in       (spi_data_in),
        .spi_busy          (spi_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flash controller: busy for busy_len cycles after a request, then next word
    int           busy_len = 2;
    int           busy_cnt;
    logic [W-1:0] next_word;
    int           n_start_seen = 0;
    int           n_cont_seen  = 0;

    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            spi_busy    <= 1'b0;
            spi_data_in <= '0;
            busy_cnt    <= 0;
            next_word   <= 16'h0001;
        end else if (spi_start_read || spi_continue_read) begin
            spi_busy <= 1'b1;
            busy_cnt <= busy_len;
            if (spi_start_read) n_start_seen <= n_start_seen + 1;
            else                n_cont_seen  <= n_cont_seen + 1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt    <= 0;
            spi_busy    <= 1'b0;
            spi_data_in <= next_word;
            next_word   <= next_word + 16'h0001;
        end
    end

    // Reference model: a queue of words plus request bookkeeping by cycle number
    logic [W-1:0] mq[$];
    bit m_stream, m_pend, m_uf, m_start, m_cont, m_stop;
    int m_req, cyc, coincide;

    task automatic model_reset();
        mq.delete();
        m_stream = 0; m_pend = 0; m_uf = 0;
        m_start = 0; m_cont = 0; m_stop = 0;
        m_req = 0; cyc = 0;
    endtask

    task automatic model_step();
        bit n_start, n_cont, n_stop, cap, pend0;
        int sz;
        logic [W-1:0] tmp;
        n_start = 0; n_cont = 0; n_stop = 0;
        pend0 = m_pend;
        if (stop_read) begin
            n_stop = 1; m_stream = 0; mq.delete(); m_pend = 0;
        end else if (!m_stream) begin
            if (read_next) begin
                n_start = 1; m_pend = 1; m_req = cyc + 1; m_stream = 1;
            end
        end else begin
            sz  = mq.size();
            cap = m_pend && (cyc >= m_req + 2) && !spi_busy;
            if (read_next) begin
                if (sz != 0) tmp = mq.pop_front();
                else         m_uf = 1;
            end
            if (cap) begin
                if (read_next && sz != 0) coincide++;
                mq.push_back(spi_data_in);
                m_pend = 0;
            end
            if (!pend0 && !m_start && !m_cont && mq.size() < DEPTH) begin
                n_cont = 1; m_pend = 1; m_req = cyc + 1;
            end
        end
        m_start = n_start; m_cont = n_cont; m_stop = n_stop;
        cyc++;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    // Per-cycle compare of every output against the model
    bit chk_en = 0;
    always @(negedge clk) begin
        if (rstn && chk_en) begin
            chk("m_data_ready", 32'(data_ready), 32'(m_stream && mq.size() != 0));
            chk("m_underflow", 32'(underflow), 32'(m_uf));
            chk("m_start", 32'(spi_start_read), 32'(m_start));
            chk("m_continue", 32'(spi_continue_read), 32'(m_cont));
            chk("m_stop", 32'(spi_stop_read), 32'(m_stop));
            if (m_stream && mq.size() != 0) chk("m_data_out", 32'(data_out), 32'(mq[0]));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(data_ready), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
        chk({tag, "_start"}, 32'(spi_start_read), 0);
        chk({tag, "_continue"}, 32'(spi_continue_read), 0);
        chk({tag, "_stop"}, 32'(spi_stop_read), 0);
        chk({tag, "_data_out"}, 32'(data_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int got, lim, s0;
        logic [W-1:0] a;

        rstn = 1'b1; read_next = 1'b0; stop_read = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        chk_en = 1;

        // Start from idle: start pulse in cycle 1, data_ready in cycle 4
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("start_c1", 32'(spi_start_read), 1);
        @(negedge clk);
        chk("start_c2_low", 32'(spi_start_read), 0);
        chk("ready_c2", 32'(data_ready), 0);
        @(negedge clk);
        chk("ready_c3", 32'(data_ready), 0);
        @(negedge clk);
        chk("ready_c4", 32'(data_ready), 1);
        chk("head_c4", 32'(data_out), 32'h0001);

        // Fill: exactly three continues, then the full FIFO stops requesting
        repeat (40) @(negedge clk);
        chk("fill_starts", 32'(n_start_seen), 1);
        chk("fill_continues", 32'(n_cont_seen), 3);
        chk("fill_head", 32'(data_out), 32'h0001);

        // Stream: pop every third cycle, words must be 1..20 in order
        got = 0; lim = 0;
        while (got < 20 && lim < 400) begin
            @(negedge clk);
            lim++;
            read_next = 1'b0;
            if ((lim % 3 == 0) && data_ready) begin
                chk($sformatf("stream_word_%0d", got), 32'(data_out), 32'(got + 1));
                read_next = 1'b1;
                got++;
            end
        end
        @(negedge clk); read_next = 1'b0;
        chk("stream_count", 32'(got), 20);

        // Push and pop in one cycle with count 2 and write pointer wrapping 3->0
        stop_read = 1'b1;
        @(negedge clk); stop_read = 1'b0;
        chk("stop_pulse_1", 32'(spi_stop_read), 1);
        repeat (4) @(negedge clk);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        lim = 0;
        while (mq.size() != 3 && lim < 100) begin @(negedge clk); lim++; end
        chk("pp_reach3", 32'(mq.size()), 3);
        a = data_out;
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("pp_pop1", 32'(data_out), 32'(a + 16'd1));
        lim = 0;
        while (!(spi_busy && busy_cnt == 1) && lim < 50) begin @(negedge clk); lim++; end
        chk("pp_landing_found", 32'(lim < 50), 1);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("pp_head", 32'(data_out), 32'(a + 16'd2));
        chk("pp_ready", 32'(data_ready), 1);
        chk("pp_model_count", 32'(mq.size()), 2);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_order_%0d", k), 32'(data_out), 32'(a + 16'(2 + k)));
            read_next = (k < 3);
            @(negedge clk);
        end
        read_next = 1'b0;
        chk("coincide_seen", 32'(coincide > 0), 1);

        // Underflow with a slow controller; sticky across stop
        stop_read = 1'b1;
        @(negedge clk); stop_read = 1'b0;
        busy_len = 10;
        repeat (4) @(negedge clk);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        repeat (2) @(negedge clk);
        chk("uf_empty", 32'(data_ready), 0);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("uf_set", 32'(underflow), 1);
        chk("uf_still_empty", 32'(data_ready), 0);
        lim = 0;
        while (!data_ready && lim < 40) begin @(negedge clk); lim++; end
        chk("uf_word_arrives", 32'(data_ready), 1);
        chk("uf_kept", 32'(underflow), 1);
        stop_read = 1'b1;
        @(negedge clk); stop_read = 1'b0;
        chk("uf_after_stop", 32'(underflow), 1);
        chk("uf_stop_pulse", 32'(spi_stop_read), 1);
        chk("uf_stop_ready", 32'(data_ready), 0);
        busy_len = 2;

        // Stop while a continue is outstanding; its word lands one cycle later
        repeat (12) @(negedge clk);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        lim = 0;
        while (!spi_continue_read && lim < 40) begin @(negedge clk); lim++; end
        chk("sm_continue_found", 32'(spi_continue_read), 1);
        @(negedge clk); stop_read = 1'b1;
        @(negedge clk); stop_read = 1'b0;
        chk("sm_stop_pulse", 32'(spi_stop_read), 1);
        chk("sm_ready_low", 32'(data_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("sm_discard_%0d", k), 32'(data_ready), 0);
        end
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("sm_restart_start", 32'(spi_start_read), 1);
        chk("sm_restart_no_cont", 32'(spi_continue_read), 0);

        // Asynchronous reset between clock edges
        repeat (8) @(negedge clk);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk_all_zero("async");
        @(negedge clk); rstn = 1'b1;
        s0 = n_start_seen;
        repeat (5) @(negedge clk);
        chk("post_reset_idle_starts", 32'(n_start_seen), 32'(s0));
        chk("post_reset_ready", 32'(data_ready), 0);
        read_next = 1'b1;
        @(negedge clk); read_next = 1'b0;
        chk("post_reset_start", 32'(spi_start_read), 1);
        repeat (10) @(negedge clk);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
